// File: rtl/tx_band_pass_filter_if.sv
// rtl/tx_band_pass_filter_if.sv - sample, coefficient and result bus of tx_band_pass_filter
//
// Signals:
//   etx_en            block enable (low = synchronous clear)
//   idata_valid/_in   input sample offer, 16-bit signed
//   odata_ready       filter can accept a sample this cycle
//   icoeff_we/_addr/_data  coefficient write port, Q1.15 signed
//   ofiltered_sample  held filter result, 16-bit signed
//   ofiltered_valid   one-cycle pulse marking a new result
//   obusy             filter is computing
// Modports: master drives samples/coefficients, slave is the filter.
interface tx_band_pass_filter_if #(
    parameter int TAPS = 128
);
    localparam int AW = $clog2(TAPS);

    logic                 etx_en;
    logic                 idata_valid;
    logic signed [15:0]   idata_in;
    logic                 odata_ready;
    logic                 icoeff_we;
    logic [AW-1:0]        icoeff_addr;
    logic signed [15:0]   icoeff_data;
    logic signed [15:0]   ofiltered_sample;
    logic                 ofiltered_valid;
    logic                 obusy;

    modport master (
        output etx_en, idata_valid, idata_in, icoeff_we, icoeff_addr, icoeff_data,
        input  odata_ready, ofiltered_sample, ofiltered_valid, obusy
    );

    modport slave (
        input  etx_en, idata_valid, idata_in, icoeff_we, icoeff_addr, icoeff_data,
        output odata_ready, ofiltered_sample, ofiltered_valid, obusy
    );
endinterface

// File: rtl/tx_band_pass_filter.sv
// rtl/tx_band_pass_filter.sv - serial-MAC FIR band-pass filter with programmable taps
//
// Ports:
//   ctx_clk  rising-edge clock
//   rtx_rst  asynchronous active-low reset
//   bus      tx_band_pass_filter_if.slave (samples in, coefficients, results out)
// One sample is accepted in IDLE; MAC walks all TAPS history entries against
// h[k], ROUND rounds/saturates the 40-bit accumulator, OUT publishes the result.
module tx_band_pass_filter #(
    parameter int TAPS  = 128,
    parameter int SHIFT = 15
) (
    input  logic                    ctx_clk,
    input  logic                    rtx_rst,
    tx_band_pass_filter_if.slave    bus
);
    localparam int AW = $clog2(TAPS);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [39:0] RND_HALF = 40'sd1 <<< (SHIFT - 1);
    localparam logic signed [39:0] SAT_MAX  = 40'sd32767;
    localparam logic signed [39:0] SAT_MIN  = -40'sd32768;

    logic [1:0]          state;
    logic signed [15:0]  hist [TAPS];
    logic signed [15:0]  coef [TAPS];
    logic [AW-1:0]       wr_ptr;
    logic [CW-1:0]       fill;
    logic [CW-1:0]       cnt;
    logic signed [39:0]  acc;
    logic signed [31:0]  prod;
    logic signed [15:0]  res_r;

    logic                ready;
    logic                accept;
    logic [AW-1:0]       rd_idx;
    logic                tap_live;
    logic signed [31:0]  x_ext;
    logic signed [31:0]  h_ext;
    logic signed [31:0]  prod_next;
    logic signed [39:0]  acc_rnd;
    logic signed [39:0]  acc_shf;
    logic signed [15:0]  sat_val;

    assign ready           = (state == S_IDLE) && bus.etx_en;
    assign accept          = ready && bus.idata_valid;
    assign bus.odata_ready = ready;
    assign bus.obusy       = (state != S_IDLE);

    // wr_ptr already points past the newest sample during MAC, so tap k
    // reads x[n-k] at wr_ptr-1-k (wraps naturally, TAPS is a power of two).
    assign rd_idx   = wr_ptr - AW'(1) - cnt[AW-1:0];
    assign tap_live = (cnt < fill);

    always_comb begin
        x_ext = '0;
        h_ext = '0;
        if (tap_live) begin
            x_ext = {{16{hist[rd_idx][15]}}, hist[rd_idx]};
            h_ext = {{16{coef[cnt[AW-1:0]][15]}}, coef[cnt[AW-1:0]]};
        end
        prod_next = x_ext * h_ext;
    end

    always_comb begin
        acc_rnd = acc + RND_HALF;
        acc_shf = acc_rnd >>> SHIFT;
        sat_val = acc_shf[15:0];
        if (acc_shf > SAT_MAX) begin
            sat_val = 16'sh7fff;
        end else if (acc_shf < SAT_MIN) begin
            sat_val = 16'sh8000;
        end
    end

    // History needs no reset: entries beyond fill are masked to zero.
    always_ff @(posedge ctx_clk) begin
        if (accept) begin
            hist[wr_ptr] <= bus.idata_in;
        end
    end

    always_ff @(posedge ctx_clk or negedge rtx_rst) begin
        if (!rtx_rst) begin
            state                <= S_IDLE;
            wr_ptr               <= '0;
            fill                 <= '0;
            cnt                  <= '0;
            acc                  <= '0;
            prod                 <= '0;
            res_r                <= '0;
            bus.ofiltered_sample <= '0;
            bus.ofiltered_valid  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (!bus.etx_en) begin
            // Coefficients and the last published sample survive a disable.
            state               <= S_IDLE;
            wr_ptr              <= '0;
            fill                <= '0;
            cnt                 <= '0;
            acc                 <= '0;
            bus.ofiltered_valid <= 1'b0;
        end else begin
            bus.ofiltered_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.icoeff_we) begin
                        coef[bus.icoeff_addr] <= bus.icoeff_data;
                    end
                    if (bus.idata_valid) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (fill != CW'(TAPS)) begin
                            fill <= fill + CW'(1);
                        end
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    // Product is registered; the add lags the multiply by one
                    // cycle, hence TAPS+1 MAC cycles for TAPS accumulations.
                    prod <= prod_next;
                    if (cnt != '0) begin
                        acc <= acc + {{8{prod[31]}}, prod};
                    end
                    if (cnt == CW'(TAPS)) begin
                        state <= S_ROUND;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_ROUND: begin
                    res_r <= sat_val;
                    state <= S_OUT;
                end
                default: begin
                    bus.ofiltered_sample <= res_r;
                    bus.ofiltered_valid  <= 1'b1;
                    state                <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tx_band_pass_filter.sv
// tb/tb_tx_band_pass_filter.sv - self-checking bench for tx_band_pass_filter
module tb_tx_band_pass_filter;
    localparam int TAPS  = 128;
    localparam int SHIFT = 15;

    logic ctx_clk = 1'b0;
    logic rtx_rst;

    always #5 ctx_clk = ~ctx_clk;

    tx_band_pass_filter_if #(.TAPS(TAPS)) bus ();

    tx_band_pass_filter #(.TAPS(TAPS), .SHIFT(SHIFT)) dut (
        .ctx_clk (ctx_clk),
        .rtx_rst (rtx_rst),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int hist_q[$];
    int coef_m[TAPS];

    always @(negedge ctx_clk) begin
        if (bus.ofiltered_valid === 1'b1) pulse_cnt++;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_out();
        longint acc = 0;
        for (int k = 0; k < hist_q.size(); k++) begin
            acc += longint'(hist_q[k]) * longint'(coef_m[k]);
        end
        acc = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    function automatic void model_push(input int x);
        hist_q.push_front(x);
        if (hist_q.size() > TAPS) void'(hist_q.pop_back());
    endfunction

    function automatic longint out_s();
        return longint'($signed(bus.ofiltered_sample));
    endfunction

    task automatic write_coef(input int k, input int v);
        @(negedge ctx_clk);
        bus.icoeff_we   = 1'b1;
        bus.icoeff_addr = 7'(k);
        bus.icoeff_data = 16'(v);
        @(posedge ctx_clk);
        #1 bus.icoeff_we = 1'b0;
        coef_m[k] = v;
    endtask

    task automatic clear_hist();
        @(negedge ctx_clk) bus.etx_en = 1'b0;
        @(negedge ctx_clk) bus.etx_en = 1'b1;
        hist_q.delete();
    endtask

    task automatic accept(input int x, output bit ok);
        @(negedge ctx_clk);
        bus.idata_valid = 1'b1;
        bus.idata_in    = 16'(x);
        for (int i = 0; i < 500 && bus.odata_ready !== 1'b1; i++) @(negedge ctx_clk);
        ok = (bus.odata_ready === 1'b1);
        if (!ok) begin
            check("accept_timeout", 0, 1);
            bus.idata_valid = 1'b0;
            return;
        end
        @(posedge ctx_clk);
        #1 bus.idata_valid = 1'b0;
        model_push(x);
    endtask

    task automatic wait_result(input string tag, input int exp);
        int cyc = 0;
        do begin
            @(posedge ctx_clk);
            #1 cyc++;
        end while (bus.ofiltered_valid !== 1'b1 && cyc < 400);
        check({tag, "_latency"}, cyc, TAPS + 3);
        check(tag, out_s(), exp);
        @(posedge ctx_clk);
        #1 check({tag, "_pulse_width"}, bus.ofiltered_valid, 0);
    endtask

    task automatic send(input int x, input string tag);
        bit ok;
        accept(x, ok);
        if (ok) wait_result(tag, model_out());
    endtask

    initial begin
        bit ok;
        int last_out;
        int held;
        int p0;
        int cyc;
        int last;
        int w;
        logic signed [15:0] r16;

        rtx_rst         = 1'b0;
        bus.etx_en      = 1'b1;
        bus.idata_valid = 1'b0;
        bus.idata_in    = '0;
        bus.icoeff_we   = 1'b0;
        bus.icoeff_addr = '0;
        bus.icoeff_data = '0;
        for (int i = 0; i < TAPS; i++) coef_m[i] = 0;

        #12;
        check("rst_sample", out_s(), 0);
        check("rst_valid", bus.ofiltered_valid, 0);
        check("rst_busy", bus.obusy, 0);
        check("rst_ready", bus.odata_ready, 1);
        @(negedge ctx_clk) rtx_rst = 1'b1;

        // single tap at one half
        write_coef(0, 16'h4000);
        send(1000, "half_gain");
        check("half_gain_const", out_s(), 500);

        // three-tap impulse response
        clear_hist();
        write_coef(0, 8192);
        write_coef(1, 16384);
        write_coef(2, 8192);
        send(2000, "imp0"); check("imp0_const", out_s(), 500);
        send(0, "imp1");    check("imp1_const", out_s(), 1000);
        send(0, "imp2");    check("imp2_const", out_s(), 500);
        send(0, "imp3");    check("imp3_const", out_s(), 0);

        // rounding at the half-LSB boundary
        clear_hist();
        write_coef(0, 1);
        write_coef(1, 0);
        write_coef(2, 0);
        send(16384, "rnd_up");    check("rnd_up_const", out_s(), 1);
        send(16383, "rnd_down");  check("rnd_down_const", out_s(), 0);
        send(-16384, "rnd_neg");  check("rnd_neg_const", out_s(), 0);

        // saturation with every tap at full scale
        for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
        for (int i = 0; i < TAPS; i++) send(-32768, "sat_neg");
        check("sat_neg_const", out_s(), -32768);
        for (int i = 0; i < TAPS; i++) send(32767, "sat_pos");
        check("sat_pos_const", out_s(), 32767);

        // reset in the middle of a MAC
        accept(1234, ok);
        p0 = pulse_cnt;
        repeat (40) @(posedge ctx_clk);
        #2 rtx_rst = 1'b0;
        #1;
        check("midrst_sample", out_s(), 0);
        check("midrst_busy", bus.obusy, 0);
        check("midrst_valid", bus.ofiltered_valid, 0);
        hist_q.delete();
        for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
        repeat (3) @(negedge ctx_clk);
        rtx_rst = 1'b1;
        repeat (200) @(posedge ctx_clk);
        check("midrst_no_pulse", pulse_cnt - p0, 0);
        write_coef(0, 16'h4000);
        write_coef(1, 16'h4000);
        send(1000, "post_rst");
        check("post_rst_const", out_s(), 500);

        // randomized coefficients and samples
        for (int k = 0; k < 16; k++) begin
            r16 = 16'($urandom);
            write_coef(k, int'(r16));
        end
        for (int i = 0; i < 24; i++) begin
            r16 = 16'($urandom);
            send(int'(r16), "rand");
        end

        // coefficient write on the accepting edge is used by that MAC
        @(negedge ctx_clk);
        check("same_edge_ready", bus.odata_ready, 1);
        bus.idata_valid = 1'b1;
        bus.idata_in    = 16'sd3000;
        bus.icoeff_we   = 1'b1;
        bus.icoeff_addr = '0;
        bus.icoeff_data = 16'sh2000;
        @(posedge ctx_clk);
        #1;
        bus.idata_valid = 1'b0;
        bus.icoeff_we   = 1'b0;
        coef_m[0] = 16'sh2000;
        model_push(3000);
        wait_result("same_edge", model_out());

        // valid held high: back-to-back accepts, ignored write during MAC
        @(negedge ctx_clk);
        bus.idata_valid = 1'b1;
        bus.idata_in    = 16'sd600;
        cyc  = 0;
        last = 0;
        for (int p = 0; p < 3; p++) begin
            model_push(600);
            w = 0;
            do begin
                @(posedge ctx_clk);
                #1 cyc++;
                w++;
                bus.icoeff_we = 1'b0;
                if (p == 1 && w == 20) begin
                    check("hold_ready_low", bus.odata_ready, 0);
                    check("hold_busy", bus.obusy, 1);
                    bus.icoeff_we   = 1'b1;
                    bus.icoeff_addr = '0;
                    bus.icoeff_data = 16'(coef_m[0] ^ 32'h5555);
                end
            end while (bus.ofiltered_valid !== 1'b1 && w < 400);
            if (p == 2) bus.idata_valid = 1'b0;
            check("hold_value", out_s(), model_out());
            if (p > 0) check("hold_period", cyc - last, TAPS + 4);
            last = cyc;
        end
        bus.icoeff_we = 1'b0;
        send(-77, "hold_after");

        // disable mid-MAC: abort, clear history, keep coefficients and output
        clear_hist();
        write_coef(0, 16'h4000);
        write_coef(1, 16'h4000);
        send(700, "en_pre");
        held = model_out();
        accept(300, ok);
        p0 = pulse_cnt;
        repeat (49) @(posedge ctx_clk);
        @(negedge ctx_clk) bus.etx_en = 1'b0;
        @(posedge ctx_clk);
        #1;
        check("en_busy", bus.obusy, 0);
        check("en_ready", bus.odata_ready, 0);
        repeat (200) @(posedge ctx_clk);
        #1;
        check("en_no_pulse", pulse_cnt - p0, 0);
        check("en_held_sample", out_s(), held);
        @(negedge ctx_clk) bus.etx_en = 1'b1;
        hist_q.delete();
        send(1000, "en_resume");
        last_out = int'(out_s());
        check("en_resume_const", last_out, 500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
